// File: rtl/encoder42_seq.sv
// encoder42_seq: sequential 4-to-2 priority encoder with a pending request
// register and a valid/ready output handshake. One code is issued per accept.
// Optional build macro ENC_RR_EN: rotating priority starting below the last
// issued code; when undefined, the highest set request bit always wins.
module encoder42_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [3:0] D,
  input  logic       ready,
  output logic [1:0] Y,
  output logic       valid,
  output logic [3:0] pending,
  output logic       ovf
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 2;

  logic [NREQ-1:0] cand;
  logic            load;
  logic [CW-1:0]   sel_idx;
  logic [CW-1:0]   y_nxt;
  logic            valid_nxt;
  logic [NREQ-1:0] pending_nxt;
  logic            ovf_nxt;

  // Candidates are the pending set plus this cycle's captured requests
  always_comb begin
    cand = pending | (E ? D : NREQ'(0));
    load = !valid || ready;
  end

`ifdef ENC_RR_EN
  logic [CW-1:0] rr_last;
  logic [CW-1:0] rr_start;
  logic [CW-1:0] rr_idx;
  logic          rr_found;

  // Rotating search: start one below the last issued code, descend with wrap
  always_comb begin
    sel_idx  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_start = rr_last - CW'(1);
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = rr_start - CW'(k);
      if (!rr_found && cand[rr_idx]) begin
        sel_idx  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Last issued code, advanced on every issuing load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= '0;
    end else if (load && (cand != '0)) begin
      rr_last <= sel_idx;
    end
  end
`else
  // Fixed priority: highest set bit wins
  always_comb begin
    sel_idx = '0;
    if (cand[3])      sel_idx = CW'(3);
    else if (cand[2]) sel_idx = CW'(2);
    else if (cand[1]) sel_idx = CW'(1);
    else              sel_idx = CW'(0);
  end
`endif

  // Next output/pending state; a load issues the selected code or goes idle
  always_comb begin
    y_nxt       = Y;
    valid_nxt   = valid;
    pending_nxt = cand;
    ovf_nxt     = E && ((D & pending) != '0);
    if (load) begin
      if (cand != '0) begin
        y_nxt       = sel_idx;
        valid_nxt   = 1'b1;
        pending_nxt = cand & ~(NREQ'(1) << sel_idx);
      end else begin
        valid_nxt   = 1'b0;
        pending_nxt = '0;
      end
    end
  end

  // Output and pending registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y       <= '0;
      valid   <= 1'b0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      Y       <= y_nxt;
      valid   <= valid_nxt;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_encoder42_seq.sv
// Testbench for encoder42_seq: reference model predicts each cycle's outputs,
// pushes them to a scoreboard queue, and pops/compares after the clock edge.
// Honours ENC_RR_EN the same way the design does.
module tb_encoder42_seq;

  typedef struct {
    logic [1:0] y;
    logic       valid;
    logic [3:0] pending;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       E;
  logic [3:0] D;
  logic       ready;
  logic [1:0] Y;
  logic       valid;
  logic [3:0] pending;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb_q[$];

  // Reference model state
  logic [1:0] m_y;
  logic       m_valid;
  logic [3:0] m_pending;
  logic [1:0] m_rr;

  encoder42_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .E       (E),
    .D       (D),
    .ready   (ready),
    .Y       (Y),
    .valid   (valid),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] pick(input logic [3:0] c, input logic [1:0] last);
    logic [1:0] r;
    r = 2'd0;
`ifdef ENC_RR_EN
    for (int k = 3; k >= 0; k--) begin
      logic [1:0] i;
      i = 2'(int'(last) - 1 - k);
      if (c[i]) r = i;
    end
`else
    for (int i = 0; i < 4; i++) if (c[i]) r = 2'(i);
`endif
    return r;
  endfunction

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input logic r, input logic e, input logic [3:0] d, input logic rdy);
    exp_t       ex;
    logic [3:0] c;
    logic [1:0] s;
    rst_n = r; E = e; D = d; ready = rdy;
    if (!r) begin
      m_y = 2'd0; m_valid = 1'b0; m_pending = 4'd0; m_rr = 2'd0;
      ex.ovf = 1'b0;
    end else begin
      c = m_pending | (e ? d : 4'd0);
      ex.ovf = e && ((d & m_pending) != 4'd0);
      if (!m_valid || rdy) begin
        if (c != 4'd0) begin
          s = pick(c, m_rr);
          m_y = s; m_valid = 1'b1; m_rr = s;
          m_pending = c & ~(4'd1 << s);
        end else begin
          m_valid = 1'b0; m_pending = 4'd0;
        end
      end else begin
        m_pending = c;
      end
    end
    ex.y = m_y; ex.valid = m_valid; ex.pending = m_pending;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      ex = sb_q.pop_front();
      check_eq("sb_valid", int'(valid), int'(ex.valid));
      if (ex.valid) check_eq("sb_y", int'(Y), int'(ex.y));
      check_eq("sb_pending", int'(pending), int'(ex.pending));
      check_eq("sb_ovf", int'(ovf), int'(ex.ovf));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    logic [1:0] burst_seq[4];
    rst_n = 1'b0; E = 1'b0; D = 4'd0; ready = 1'b0;
    m_y = 2'd0; m_valid = 1'b0; m_pending = 4'd0; m_rr = 2'd0;
    @(negedge clk);

    // Reset dominates full requests and ready
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check_eq("rst_y", int'(Y), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    check_eq("rel_valid", int'(valid), 1);
    check_eq("rel_y", int'(Y), 3);
    idle(5);

    // One-hot requests, one per index
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 4'(1 << i), 1'b1);
      check_eq("single_y", int'(Y), i);
      check_eq("single_valid", int'(valid), 1);
      check_eq("single_pending", int'(pending), 0);
      step(1'b1, 1'b0, 4'd0, 1'b1);
      check_eq("single_drop", int'(valid), 0);
    end

    // Burst from reset state: 3,2,1,0 in both builds
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    check_eq("burst_y0", int'(Y), 3);
    step(1'b1, 1'b0, 4'd0, 1'b1); check_eq("burst_y1", int'(Y), 2);
    step(1'b1, 1'b0, 4'd0, 1'b1); check_eq("burst_y2", int'(Y), 1);
    step(1'b1, 1'b0, 4'd0, 1'b1); check_eq("burst_y3", int'(Y), 0);
    step(1'b1, 1'b0, 4'd0, 1'b1); check_eq("burst_end", int'(valid), 0);

    // Burst after a grant of 2
`ifdef ENC_RR_EN
    burst_seq = '{2'd1, 2'd0, 2'd3, 2'd2};
`else
    burst_seq = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check_eq("pre_grant", int'(Y), 2);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    check_eq("burst2_y", int'(Y), int'(burst_seq[0]));
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      check_eq("burst2_y", int'(Y), int'(burst_seq[k]));
    end
    idle(2);

    // Stall holds Y; release drains remaining request
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'd0, 1'b0);
    check_eq("stall_y", int'(Y), 2);
    check_eq("stall_valid", int'(valid), 1);
    check_eq("stall_pending", int'(pending), 1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check_eq("stall_rel_y", int'(Y), 0);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check_eq("stall_rel_end", int'(valid), 0);

    // Overflow on an already-pending bit, then E=0 ignores D
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 1'b0);
    step(1'b1, 1'b1, 4'b0011, 1'b0);
    check_eq("ovf_pulse", int'(ovf), 1);
    check_eq("ovf_pending", int'(pending), 3);
    step(1'b1, 1'b0, 4'b1000, 1'b0);
    check_eq("ovf_clear", int'(ovf), 0);
    check_eq("e0_pending", int'(pending), 3);
    step(1'b1, 1'b0, 4'd0, 1'b1); check_eq("ovf_drain_y", int'(Y), 1);
    idle(3);

    // Re-request of the held code and same-cycle handshake+request
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check_eq("hs_same_valid", int'(valid), 1);
    check_eq("hs_same_ovf", int'(ovf), 0);
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    check_eq("held_req_ovf", int'(ovf), 0);
    check_eq("held_req_pending", int'(pending), 4);
    idle(3);

    // Reset in the middle of a burst
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check_eq("mid_pending", int'(pending), 3);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("mid_valid", int'(valid), 0);
    check_eq("mid_pending0", int'(pending), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      check_eq("mid_quiet", int'(valid), 0);
    end

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder42_seq.md
Name: encoder42_seq

Overview:
- Sequential 4-to-2 encoder. It is the inverse of the team's 2-4 decoder: it turns one-hot or multi-hot request lines D[3:0] back into a 2-bit code Y.
- Requests are latched into a pending register. One code is issued at a time on a valid/ready output handshake, highest-priority request first.
- Sits between request sources (for example decoder-driven select lines) and a consumer that accepts one index per handshake.

Parameters:
- None. Width is fixed at 4 inputs and 2-bit code.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
- E  input  1  capture enable; when 0, D is ignored for that cycle
- D  input  4  request lines; bit i requests code i
- ready  input  1  consumer accepts the current Y when valid=1 and ready=1
- Y  output  2  encoded index of the granted request
- valid  output  1  Y holds an unaccepted code
- pending  output  4  requests captured but not yet issued
- ovf  output  1  one-cycle pulse: a request hit a bit that was already pending (request merged, one lost)

Behaviour:
- Reset: rst_n=0 at a clock edge sets Y=2'b00, valid=0, pending=4'b0000, ovf=0. If ENC_RR_EN is compiled in, it also sets rr_last=2'b00. Reset takes priority over every other event, including a handshake in the same cycle.
- Reset mid-operation drops all pending requests and any unaccepted Y without notice.
- Candidate set each cycle: cand = pending | (E ? D : 4'b0000).
- Load condition: load = !valid || ready. Output is free, or the current code is accepted this cycle.
- If load and cand != 0:
  - Y <= sel(cand), valid <= 1
  - pending <= cand with bit sel(cand) cleared
- If load and cand == 0: valid <= 0, Y holds its old value, pending <= 0.
- If not load: Y and valid hold; pending <= cand.
- sel() with fixed priority: highest set bit wins (bit 3 > 2 > 1 > 0).
- Latency: D asserted with E=1 in cycle n, with the output free, gives valid=1 and the matching Y in cycle n+1.
- Back-to-back issue: with ready held at 1, one code is issued per cycle. All four bits asserted together issue 3,2,1,0 on consecutive cycles.
- Stall: valid=1 and ready=0 holds Y stable for any number of cycles. New requests keep accumulating in pending.
- ovf rule:
  - ovf <= 1 for exactly one cycle when E=1 and (D & pending) != 0. It is based on the registered pending value.
  - The duplicate request is merged, not queued twice.
  - A request on the bit currently held in Y (already issued, not pending) is not an overflow. It re-enters pending.
- Simultaneous events: a handshake plus a new request on the same bit in the same cycle is accepted. The new request is eligible for selection in that cycle's load.
- E=0 with D nonzero: no capture, pending unchanged, and issuing from pending continues normally.

Optional Feature:
- Macro: ENC_RR_EN
- Defined:
  - sel() uses rotating priority.
  - An internal 2-bit rr_last register records the last issued code.
  - Search starts at bit (rr_last-1) mod 4 and descends with wrap.
  - rr_last updates on every load that issues.
  - rr_last resets to 0, so the first search starts at bit 3, identical to fixed priority.
- Undefined: fixed priority as above, no rr_last register.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while D=4'b1111, E=1, ready=1 -> Y=00, valid=0, pending=0000, ovf=0. Release rst_n -> next cycle valid=1, Y=11.
- Single request per index: for i in 0..3, D=one-hot(i) with E=1 for one cycle, ready=1 -> valid=1 with Y=i in the next cycle only. pending=0000 throughout.
- Burst: D=4'b1111, E=1 for one cycle, then D=0, ready=1 -> Y sequence 11,10,01,00 on 4 consecutive cycles, then valid=0.
  - With ENC_RR_EN, the same burst after a prior grant of 2 -> sequence 01,00,11,10.
- Stall: D=4'b0101, E=1 for one cycle, ready=0 for 5 cycles -> Y=10 stable, valid=1, pending=0001. Raise ready -> Y=00 next cycle, then valid=0.
- Overflow: with pending=0001 under stall, apply D=4'b0011, E=1 -> ovf=1 for one cycle, pending=0011. Then apply E=0 with D=4'b1000 -> pending unchanged, ovf=0.
- Mid-operation reset: during a burst with pending=0011 and valid=1, assert rst_n=0 with ready=1 -> next cycle valid=0, pending=0000. No further codes appear after release while D=0.
